// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: sync inputs and recovered timing outputs of the
// VGA sync decoder. master = sync source side, slave = decoder side.
//   hSync, vSync      sync inputs (source -> decoder)
//   xPos, yPos        active-area column / row
//   pixelValid        visible, locked pixel qualifier
//   frameStart        one-cycle pulse on the vSync assertion edge
//   locked            horizontal and vertical timing verified
//   syncErr           one-cycle pulse on a timing violation
//   frameCount        (VGA_SYNC_DECODER_STATS_EN only) locked frames seen
//   errCount          (VGA_SYNC_DECODER_STATS_EN only) saturating error count
interface vga_sync_decoder_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          hSync;
    logic          vSync;
    logic [XW-1:0] xPos;
    logic [YW-1:0] yPos;
    logic          pixelValid;
    logic          frameStart;
    logic          locked;
    logic          syncErr;
`ifdef VGA_SYNC_DECODER_STATS_EN
    logic [15:0]   frameCount;
    logic [7:0]    errCount;
`endif

    modport master (
        output hSync,
        output vSync,
        input  xPos,
        input  yPos,
        input  pixelValid,
        input  frameStart,
        input  locked,
        input  syncErr
`ifdef VGA_SYNC_DECODER_STATS_EN
        ,
        input  frameCount,
        input  errCount
`endif
    );

    modport slave (
        input  hSync,
        input  vSync,
        output xPos,
        output yPos,
        output pixelValid,
        output frameStart,
        output locked,
        output syncErr
`ifdef VGA_SYNC_DECODER_STATS_EN
        ,
        output frameCount,
        output errCount
`endif
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, active-area qualifier,
// frame-start pulse, lock status and sync errors from hSync/vSync.
// Ports: pixelClk (rising edge), rst (synchronous, active-low),
//   bus (vga_sync_decoder_if.slave): hSync/vSync in; xPos, yPos,
//   pixelValid, frameStart, locked, syncErr out.
// Optional macro VGA_SYNC_DECODER_STATS_EN adds frameCount/errCount.
module vga_sync_decoder #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_POL   = 0,
    parameter int LOCK_LINES = 4
) (
    input logic              pixelClk,
    input logic              rst,
    vga_sync_decoder_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int GW = $clog2(LOCK_LINES + 1);

    localparam logic          ASSERTED = 1'(SYNC_POL);
    localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_LO     = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_HI     = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_LO     = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_HI     = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [GW-1:0] G_LOCK   = GW'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [GW-1:0] good;
    logic [GW-1:0] good_n;

    logic          hs_q;
    logic          hs_d;
    logic          vs_q;
    logic          vs_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          v_ok;
    logic          locked_q;
    logic          pv_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          fs_q;
    logic          err_q;

    logic          h_edge;
    logic          v_edge;
    logic          h_len_ok;
    logic          v_len_ok;
    logic          h_err;
    logic          v_err;
    logic          h_win;
    logic          v_win;

    // Edges come from the registered sync vs. its one-cycle-older copy.
    assign h_edge   = (hs_q == ASSERTED) && (hs_d != ASSERTED);
    assign v_edge   = (vs_q == ASSERTED) && (vs_d != ASSERTED);
    assign h_len_ok = (h_cnt == H_LAST);
    assign v_len_ok = (v_cnt == V_LAST);
    // A frame length error only counts once a good frame has been seen.
    assign v_err    = v_edge && v_ok && !v_len_ok;
    assign h_win    = (h_cnt >= H_LO) && (h_cnt <= H_HI);
    assign v_win    = (v_cnt >= V_LO) && (v_cnt <= V_HI);

    always_comb begin
        state_n = state;
        good_n  = good;
        h_err   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (h_edge) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
            end
            ACQUIRE: begin
                if (h_edge) begin
                    if (h_len_ok) begin
                        good_n = good + 1'b1;
                        if (good_n == G_LOCK) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        good_n = '0;
                        h_err  = 1'b1;
                    end
                end else if (h_cnt == H_MAX) begin
                    h_err   = 1'b1;
                    state_n = SEARCH;
                end
            end
            LOCKED: begin
                if (h_edge) begin
                    if (!h_len_ok) begin
                        h_err   = 1'b1;
                        state_n = ACQUIRE;
                        good_n  = '0;
                    end
                end else if (h_cnt == H_MAX) begin
                    h_err   = 1'b1;
                    state_n = SEARCH;
                end
            end
            default: begin
                state_n = SEARCH;
                good_n  = '0;
            end
        endcase
    end

    always_ff @(posedge pixelClk) begin
        if (!rst) begin
            hs_q     <= ~ASSERTED;
            hs_d     <= ~ASSERTED;
            vs_q     <= ~ASSERTED;
            vs_d     <= ~ASSERTED;
            h_cnt    <= '0;
            v_cnt    <= '0;
            state    <= SEARCH;
            good     <= '0;
            v_ok     <= 1'b0;
            locked_q <= 1'b0;
            pv_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            fs_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            hs_q  <= bus.hSync;
            hs_d  <= hs_q;
            vs_q  <= bus.vSync;
            vs_d  <= vs_q;
            state <= state_n;
            good  <= good_n;

            if (h_edge) begin
                h_cnt <= '0;
            end else if (h_cnt != H_MAX) begin
                h_cnt <= h_cnt + 1'b1;
            end

            // vSync restart wins over a coincident hSync edge.
            if (v_edge) begin
                v_cnt <= '0;
                v_ok  <= v_len_ok;
            end else if (h_edge && v_cnt != V_MAX) begin
                v_cnt <= v_cnt + 1'b1;
            end

            locked_q <= (state == LOCKED) && v_ok;
            pv_q     <= h_win && v_win && locked_q;
            if (h_win && v_win) begin
                x_q <= XW'(h_cnt - H_LO);
                y_q <= YW'(v_cnt - V_LO);
            end

            fs_q  <= v_edge;
            err_q <= h_err || v_err;
        end
    end

    assign bus.xPos       = x_q;
    assign bus.yPos       = y_q;
    assign bus.pixelValid = pv_q;
    assign bus.frameStart = fs_q;
    assign bus.locked     = locked_q;
    assign bus.syncErr    = err_q;

`ifdef VGA_SYNC_DECODER_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    always_ff @(posedge pixelClk) begin
        if (!rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (v_edge && locked_q) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if ((h_err || v_err) && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign bus.frameCount = frame_cnt;
    assign bus.errCount   = err_cnt;
`endif
endmodule
